// File: rtl/muldiv_pkg.sv
// Shared encodings, state enum and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [XLEN_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN_W-1:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // rs1 is treated as signed for these ops
  function automatic logic op_signed_a(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_signed_b(input logic [2:0] f);
    return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  function automatic logic [XLEN_W-1:0] neg_if(input logic neg, input logic [XLEN_W-1:0] v);
    return neg ? XLEN_W'(-v) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Partial remainder stays below the divisor, so the MSB of diff is a clean borrow flag
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[XLEN];
    rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with PC stall and one-cycle done pulse.
// Define MULDIV_FAST_MUL_EN to resolve all multiplies in one cycle with a hardware multiplier.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int unsigned ACC_W = 2 * XLEN;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [XLEN-1:0]    opa_q, opa_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               acc_start;
  logic               sa_c, sb_c;
  logic               div_ovf_c;
  logic [XLEN:0]      mul_sum_c;
  logic [XLEN-1:0]    step_rem_c;
  logic               step_q_c;
  logic [ACC_W-1:0]   prod_fix_c;
  logic [XLEN-1:0]    fix_result_c;

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_i          (acc_q[ACC_W-1:XLEN]),
    .dividend_bit_i (opa_q[~cnt_q]),
    .divisor_i      (opb_q),
    .rem_o          (step_rem_c),
    .q_o            (step_q_c)
  );

  assign acc_start = start & ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sa_c      = op_signed_a(funct3) & rs1[XLEN-1];
  assign sb_c      = op_signed_b(funct3) & rs2[XLEN-1];
  assign div_ovf_c = (funct3 == OP_DIV || funct3 == OP_REM) &&
                     (rs1 == INT_MIN) && (rs2 == '1);

  // Shift-add: add the multiplicand into the upper half, then shift the whole accumulator right
  assign mul_sum_c = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, (opb_q[cnt_q] ? opa_q : '0)};

  // Sign correction and word selection for the FIX cycle
  always_comb begin
    prod_fix_c   = (sign_a_q ^ sign_b_q) ? ACC_W'(-acc_q) : acc_q;
    fix_result_c = '0;
    unique case (op_q)
      OP_MUL:                       fix_result_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result_c = prod_fix_c[ACC_W-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result_c = neg_if(sign_a_q ^ sign_b_q, acc_q[XLEN-1:0]);
      OP_REM, OP_REMU:              fix_result_c = neg_if(sign_a_q, acc_q[ACC_W-1:XLEN]);
      default:                      fix_result_c = '0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [ACC_W-1:0] fast_a_c, fast_b_c, fast_prod_c;
  // Sign-extended 33-bit operands; the low 64 bits of the product are exact for every mode
  assign fast_a_c    = {{XLEN{op_signed_a(funct3) & rs1[XLEN-1]}}, rs1};
  assign fast_b_c    = {{XLEN{op_signed_b(funct3) & rs2[XLEN-1]}}, rs2};
  assign fast_prod_c = fast_a_c * fast_b_c;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (acc_start) begin
          op_d     = op_e'(funct3);
          sign_a_d = sa_c;
          sign_b_d = sb_c;
          opa_d    = neg_if(sa_c, rs1);
          opb_d    = neg_if(sb_c, rs2);
          acc_d    = '0;
          cnt_d    = '0;
          if (funct3[2]) begin
            if (rs2 == '0) begin
              result_d = funct3[1] ? rs1 : DIV_BY_ZERO_Q;
              state_d  = S_DONE;
            end else if (div_ovf_c) begin
              result_d = funct3[1] ? '0 : INT_MIN;
              state_d  = S_DONE;
            end else begin
              state_d  = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = (funct3 == OP_MUL) ? fast_prod_c[XLEN-1:0] : fast_prod_c[ACC_W-1:XLEN];
            state_d  = S_DONE;
`else
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {step_rem_c, acc_q[XLEN-2:0], step_q_c};
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_result_c;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = busy_q | (start & (state_q == S_IDLE));

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations in the single-cycle core. When the decoder flags an R-type instruction with funct7[0]=1, the core pulses `start` with funct3 and the two register operands. The block runs the operation iteratively and holds the PC via `stall` until the result is ready. The result is then presented for one writeback cycle.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk` input 1: core clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an M-extension op; sampled only in IDLE or DONE.
- `funct3` input 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` input XLEN: dividend / multiplicand.
- `rs2` input XLEN: divisor / multiplier.
- `busy` output 1: operation in progress (states MUL, DIV, FIX).
- `done` output 1: result valid; high for exactly one cycle (state DONE).
- `result` output XLEN: registered result; held until the next accepted start or reset.
- `stall` output 1: combinational `busy | (start & state==IDLE)`; the PC and register write are held while high.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset: state IDLE; `busy`=0, `done`=0, `result`=0; iteration counter 0; operand registers 0.
- Accept (state IDLE or DONE with `start`=1):
  - latch funct3;
  - record operand signs according to the op (signed: MULH, DIV, REM; rs1 only: MULHSU);
  - store absolute values;
  - clear the 64-bit accumulator;
  - clear the counter to 0.
- Special cases, resolved at accept with no iteration; next state DONE:
  - divisor 0: DIV/DIVU give 0xFFFFFFFF, REM/REMU give rs1;
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000;
  - REM with the same operands gives 0.
- MUL state: shift-add, one multiplier bit per cycle, 32 cycles, then FIX.
- DIV state: restoring division, one quotient bit per cycle, 32 cycles, then FIX.
- FIX state (1 cycle):
  - apply two's-complement negation when the signs differ: quotient sign is the XOR of operand signs, remainder takes the dividend sign, product sign is the XOR of recorded signs;
  - select low or high product word, or quotient or remainder;
  - write `result`;
  - next state DONE.
- DONE: `done`=1. With `start` the block accepts the next op (back-to-back); without it, the next state is IDLE.
- `start` in MUL, DIV or FIX is ignored; no queuing.
- `rst` during any state aborts the operation immediately and returns to IDLE with the reset values above.
- Counter: 5-bit, wraps 31→0 on the last iteration; the last iteration is the one with the counter at 31.

## Timing
- Start accepted at edge T:
  - iterative ops: `busy` high in cycles T+1…T+33 (32 iterate + 1 FIX); `done` and valid `result` in cycle T+34.
  - special-case divide: `done` in cycle T+1.
  - fast multiply (macro on): `done` in cycle T+1.
- `stall` is high from the accept cycle through the last busy cycle, and low in DONE so the core retires the instruction.
- `done` never overlaps `busy`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - all four multiply ops use a single-cycle 33×33 signed multiplier at accept;
  - MUL and FIX states are skipped;
  - latency is 1.
- `MULDIV_FAST_MUL_EN` undefined:
  - no hardware multiplier is instantiated;
  - multiplies use the 34-cycle iterative path.
- Division is iterative in both builds.

## Structure
- Shared package `muldiv_pkg`: funct3 op encodings, the state enum, and the constants `DIV_BY_ZERO_Q` (0xFFFFFFFF) and `INT_MIN` (0x80000000).
- One sub-module, `div_restore_step`: combinational single restoring-division step. Inputs are the partial remainder, dividend bit and divisor; outputs are the next remainder and quotient bit.

## Test plan
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → `result` 0xFFFFFFFD at T+34. REM on the same operands → 0xFFFFFFFF. `stall` high T…T+33.
- DIVU 0x0000000A/0 → 0xFFFFFFFF at T+1. REMU on the same operands → 0x0000000A. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MUL 3×0xFFFFFFFE → 0xFFFFFFFA. Run in both macro builds; check latency 34 vs 1.
- Pulse `start` again at T+10 during a DIV → ignored, original result unchanged. Assert `start` in the DONE cycle → second op accepted with no IDLE gap.
- Assert `rst` at T+15 of a DIV → next cycle IDLE with `busy`=0, `done`=0, `result`=0. No `done` appears afterwards.
